// File: rtl/bg_pkg.sv
// bg_pkg
//   Shared types and constants for the tiled background renderer.
//   rgb_t       : 12-bit output colour
//   pal_idx_t   : 2-bit palette index stored in the tile
//   BG_TILE     : 32x32 soil tile. Each row is one 64-bit word, and BG_TILE[ty][tx]
//                 is the 2-bit index at column tx (column 0 sits in the low bits).
//   BG_DEF_PAL  : palette loaded into every band at reset
//   Helpers     : bg_tile_pix (tile lookup), bg_def_color (reset colour per index)
package bg_pkg;

    localparam int BG_TILE_DIM = 32;
    localparam int BG_BPP      = 2;
    localparam int BG_RGB_W    = 12;

    typedef logic [BG_RGB_W-1:0] rgb_t;
    typedef logic [BG_BPP-1:0]   pal_idx_t;

    localparam logic [BG_TILE_DIM-1:0][BG_BPP-1:0] BG_TILE [BG_TILE_DIM] = '{
        64'h5A96_1B27_D8E4_6C93,
        64'h9C3E_72A5_1F84_B6D0,
        64'h27B1_E5C8_409F_3A6E,
        64'hE0D6_9B43_A72C_158F,
        64'h4F82_C61D_3E97_0AB4,
        64'hB375_08EA_D41C_962B,
        64'h1DA9_F437_6B02_E8C6,
        64'h86E4_2D9B_C150_7F3A,
        64'h3C0F_A658_97E2_4DB1,
        64'hD748_1EB3_0C6A_F259,
        64'h6A2D_B90F_E583_17C4,
        64'hF19B_4C76_283D_A0E5,
        64'h08C3_E7A1_5FB6_9D42,
        64'hA5E7_3280_D9C4_6B1F,
        64'h7B16_C9D4_A03E_852F,
        64'hC2F0_8B5E_1796_D3A8,
        64'h4E69_D2A3_F80B_7C15,
        64'h918A_6F0C_B3E5_2D47,
        64'hE5D3_07B8_4A19_C62F,
        64'h3B74_A1E6_9D2C_08F5,
        64'h5C0E_9B37_62F4_A18D,
        64'hA6F2_4D81_C75B_3E09,
        64'h0D9B_E364_A12F_85C7,
        64'h8F41_C2AD_5E06_B739,
        64'h62C8_1F9E_D73A_04BD,
        64'hD05A_B6C2_38E1_9F74,
        64'h29E7_45F0_AC8D_163B,
        64'hB4A1_E83D_0F62_C95E,
        64'h7E3C_920B_D15A_68F4,
        64'hC8D5_3A46_E0B7_21F9,
        64'h1A6F_D7C2_9483_E50B,
        64'hF7B2_068D_3C1E_A451
    };

    localparam rgb_t BG_DEF_PAL [4] = '{12'h000, 12'hC60, 12'hFFC, 12'h630};

    function automatic pal_idx_t bg_tile_pix(input logic [4:0] ty, input logic [4:0] tx);
        return BG_TILE[ty][tx];
    endfunction

    // Indices beyond the four defined soil colours reset to black.
    function automatic rgb_t bg_def_color(input int unsigned idx);
        if (idx < 4) begin
            return BG_DEF_PAL[idx[1:0]];
        end
        return '0;
    endfunction

endpackage

// File: rtl/tiled_bg_renderer_if.sv
// tiled_bg_renderer_if
//   Pixel stream, scroll, palette write port and background output of the renderer.
//   master : pixel counter / CPU side (drives pixels, scroll, palette writes)
//   slave  : renderer side (drives background_RGB, bg_valid)
//   Signals: pixelX, pixelY, pixel_valid, startOfFrame, scroll_x, scroll_y,
//            pal_we, pal_band, pal_idx, pal_data, background_RGB, bg_valid
interface tiled_bg_renderer_if #(
    parameter int TILE_W    = 32,
    parameter int TILE_H    = 32,
    parameter int BPP       = 2,
    parameter int RGB_W     = 12,
    parameter int XY_W      = 11,
    parameter int NUM_BANDS = 4
);

    logic [XY_W-1:0]              pixelX;
    logic [XY_W-1:0]              pixelY;
    logic                         pixel_valid;
    logic                         startOfFrame;
    logic [$clog2(TILE_W)-1:0]    scroll_x;
    logic [$clog2(TILE_H)-1:0]    scroll_y;
    logic                         pal_we;
    logic [$clog2(NUM_BANDS)-1:0] pal_band;
    logic [BPP-1:0]               pal_idx;
    logic [RGB_W-1:0]             pal_data;
    logic [RGB_W-1:0]             background_RGB;
    logic                         bg_valid;

    modport master (
        output pixelX, pixelY, pixel_valid, startOfFrame, scroll_x, scroll_y,
        output pal_we, pal_band, pal_idx, pal_data,
        input  background_RGB, bg_valid
    );

    modport slave (
        input  pixelX, pixelY, pixel_valid, startOfFrame, scroll_x, scroll_y,
        input  pal_we, pal_band, pal_idx, pal_data,
        output background_RGB, bg_valid
    );

endinterface

// File: rtl/bg_palette_bank.sv
// bg_palette_bank
//   Double-buffered per-band palette. Writes go to the shadow copy; commit copies
//   the whole shadow array into the active copy that the renderer reads.
//   Ports:
//     clk, resetN        pixel clock, async active-low reset
//     pal_we/band/idx/data  shadow write port
//     commit             copy shadow -> active (start of frame)
//     rd_band, rd_idx    active palette read address
//     rd_color           combinational read data
module bg_palette_bank
    import bg_pkg::*;
#(
    parameter int BPP       = 2,
    parameter int RGB_W     = 12,
    parameter int NUM_BANDS = 4
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         pal_we,
    input  logic [$clog2(NUM_BANDS)-1:0] pal_band,
    input  logic [BPP-1:0]               pal_idx,
    input  logic [RGB_W-1:0]             pal_data,
    input  logic                         commit,
    input  logic [$clog2(NUM_BANDS)-1:0] rd_band,
    input  logic [BPP-1:0]               rd_idx,
    output logic [RGB_W-1:0]             rd_color
);

    localparam int BAND_W  = $clog2(NUM_BANDS);
    localparam int NUM_IDX = 2 ** BPP;

    logic [RGB_W-1:0] shadow_pal [NUM_BANDS][NUM_IDX];
    logic [RGB_W-1:0] active_pal [NUM_BANDS][NUM_IDX];

    // The commit reads shadow_pal before this edge's write lands, so a write
    // coincident with commit only becomes visible at the following commit.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                for (int i = 0; i < NUM_IDX; i++) begin
                    shadow_pal[BAND_W'(b)][BPP'(i)] <= RGB_W'(bg_def_color(i));
                    active_pal[BAND_W'(b)][BPP'(i)] <= RGB_W'(bg_def_color(i));
                end
            end
        end else begin
            if (pal_we) begin
                shadow_pal[pal_band][pal_idx] <= pal_data;
            end
            if (commit) begin
                active_pal <= shadow_pal;
            end
        end
    end

    assign rd_color = active_pal[rd_band][rd_idx];

endmodule

// File: rtl/tiled_bg_renderer.sv
// tiled_bg_renderer
//   Repeats a 32x32 2-bpp soil tile across the screen and colours it through a
//   per-band palette. Two-stage pipeline:
//     stage 1: tile index and band from the (scrolled) pixel coordinates
//     stage 2: palette lookup into the registered background_RGB
//   Scroll offsets and the palette are taken over at startOfFrame.
//   Ports:
//     clk     pixel clock
//     resetN  async active-low reset
//     bus     tiled_bg_renderer_if.slave (pixel stream, scroll, palette write, output)
//   Build option: define BG_SCROLL_EN to latch scroll_x/scroll_y at startOfFrame.
//   Without it the scroll inputs are ignored and the tile is rendered unscrolled.
module tiled_bg_renderer
    import bg_pkg::*;
#(
    parameter int TILE_W    = 32,
    parameter int TILE_H    = 32,
    parameter int BPP       = 2,
    parameter int RGB_W     = 12,
    parameter int XY_W      = 11,
    parameter int NUM_BANDS = 4,
    parameter int BAND_H    = 120
) (
    input logic                 clk,
    input logic                 resetN,
    tiled_bg_renderer_if.slave  bus
);

    localparam int TXW    = $clog2(TILE_W);
    localparam int TYW    = $clog2(TILE_H);
    localparam int BAND_W = $clog2(NUM_BANDS);

    logic [TXW-1:0]    sx_act;
    logic [TYW-1:0]    sy_act;
    logic [TXW-1:0]    tx;
    logic [TYW-1:0]    ty;
    logic [BPP-1:0]    idx_c;
    logic [BAND_W-1:0] band_c;

    logic              s1_valid;
    logic [BPP-1:0]    s1_idx;
    logic [BAND_W-1:0] s1_band;
    logic [RGB_W-1:0]  rd_color;

`ifdef BG_SCROLL_EN
    // Offsets only change at frame boundaries so a frame never tears mid-scan.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sx_act <= '0;
            sy_act <= '0;
        end else if (bus.startOfFrame) begin
            sx_act <= bus.scroll_x;
            sy_act <= bus.scroll_y;
        end
    end
`else
    assign sx_act = '0;
    assign sy_act = '0;
`endif

    // Tile dimensions are powers of two, so keeping only the low bits of the
    // sum gives the wrap-around for free.
    assign tx    = bus.pixelX[TXW-1:0] + sx_act;
    assign ty    = bus.pixelY[TYW-1:0] + sy_act;
    assign idx_c = BPP'(bg_tile_pix(5'(ty), 5'(tx)));

    // Band boundaries are constants; scanning from the top boundary down leaves
    // the lowest matching band, and anything below the last boundary clamps.
    always_comb begin
        band_c = BAND_W'(NUM_BANDS - 1);
        for (int k = NUM_BANDS - 1; k >= 1; k--) begin
            if (bus.pixelY < XY_W'(k * BAND_H)) begin
                band_c = BAND_W'(k - 1);
            end
        end
    end

    // Stage 1: tile index and band for the incoming pixel.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_band  <= '0;
        end else begin
            s1_valid <= bus.pixel_valid;
            if (bus.pixel_valid) begin
                s1_idx  <= idx_c;
                s1_band <= band_c;
            end
        end
    end

    bg_palette_bank #(
        .BPP       (BPP),
        .RGB_W     (RGB_W),
        .NUM_BANDS (NUM_BANDS)
    ) u_palette (
        .clk      (clk),
        .resetN   (resetN),
        .pal_we   (bus.pal_we),
        .pal_band (bus.pal_band),
        .pal_idx  (bus.pal_idx),
        .pal_data (bus.pal_data),
        .commit   (bus.startOfFrame),
        .rd_band  (s1_band),
        .rd_idx   (s1_idx),
        .rd_color (rd_color)
    );

    // Stage 2: colour register. It holds its last colour through blanking so
    // the object mux never sees a glitch on the fallback layer.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            bus.background_RGB <= '0;
            bus.bg_valid       <= 1'b0;
        end else begin
            bus.bg_valid <= s1_valid;
            if (s1_valid) begin
                bus.background_RGB <= rd_color;
            end
        end
    end

endmodule
